// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic echo responder and the ranger bench:
// FSM state encoding, default timing constants and the echo width clamp.
package ultrasonic_pkg;

  localparam int unsigned STATE_W = 3;

  // Default timing, in clk cycles at 50 MHz
  localparam int unsigned MIN_TRIG_DEF = 500;      // 10 us minimum trigger width
  localparam int unsigned TDELAY_DEF   = 25000;    // acoustic delay, trig fall to echo rise
  localparam int unsigned MAX_ECHO_DEF = 1900000;  // 38 ms, no-reflection echo width
  localparam int unsigned THOLD_DEF    = 500000;   // re-arm holdoff after echo

  // Encodings 5..7 are unused and fall back to S_IDLE
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_DELAY = 3'd2,
    S_ECHO  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // Echo width for a request: full window when no target, otherwise the
  // requested width forced into [1, max_w] with an unsigned compare.
  function automatic logic [31:0] echo_width(input logic        no_tgt,
                                             input logic [31:0] cfg,
                                             input logic [31:0] max_w);
    logic [31:0] w;
    if (no_tgt)
      w = max_w;
    else if (cfg == 32'd0)
      w = 32'd1;
    else if (cfg > max_w)
      w = max_w;
    else
      w = cfg;
    return w;
  endfunction

endpackage

// File: rtl/ultrasonic_echo_responder_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
  input  logic Clock,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both clear on reset
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 style sensor model: qualifies a Trig pulse, waits a fixed acoustic
// delay, then drives Echo for a programmable width, followed by a holdoff.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for a Trig rising edge
//  S_ARM   | Trig high, measuring its width against MIN_TRIG
//  S_DELAY | valid Trig seen, counting the acoustic delay
//  S_ECHO  | Echo high, counting down the latched width
//  S_HOLD  | holdoff before re-arming; Trig ignored
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned MIN_TRIG = MIN_TRIG_DEF,
  parameter int unsigned TDELAY   = TDELAY_DEF,
  parameter int unsigned MAX_ECHO = MAX_ECHO_DEF,
  parameter int unsigned THOLD    = THOLD_DEF
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Trig,
  input  logic [31:0]        dist_cfg,
  input  logic               no_target,
  output logic               Echo,
  output logic               busy,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         short_cnt,
  output logic [15:0]        echo_cnt
);

  localparam logic [31:0] MIN_TRIG_C = 32'(MIN_TRIG);
  localparam logic [31:0] TDELAY_C   = 32'(TDELAY);
  localparam logic [31:0] MAX_ECHO_C = 32'(MAX_ECHO);
  localparam logic [31:0] THOLD_C    = 32'(THOLD);

  state_t      state_q;
  logic [31:0] count;
  logic [31:0] width;
  logic        trig_s;
  logic        trig_q;
  logic        rise;

  sync_2ff u_trig_sync (
    .Clock (Clock),
    .Reset (Reset),
    .d     (Trig),
    .q     (trig_s)
  );

  // One-cycle delayed copy of the synchronised trigger for edge detection
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) trig_q <= 1'b0;
    else       trig_q <= trig_s;
  end

  assign rise = trig_s & ~trig_q;

  // Sequencing FSM with its shared down-counter, latched width and statistics
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      count     <= 32'd0;
      width     <= 32'd0;
      short_cnt <= 8'd0;
      echo_cnt  <= 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_q <= S_ARM;
            count   <= 32'd1;
          end
        end

        S_ARM: begin
          if (trig_s) begin
            // Only need to know "long enough", so stop counting at MIN_TRIG
            if (count < MIN_TRIG_C)
              count <= count + 32'd1;
          end else if (count >= MIN_TRIG_C) begin
            state_q <= S_DELAY;
            count   <= TDELAY_C - 32'd1;
            // Width is captured once here so later config changes cannot
            // disturb the pulse in flight
            width   <= echo_width(no_target, dist_cfg, MAX_ECHO_C);
          end else begin
            state_q <= S_IDLE;
            count   <= 32'd0;
            if (short_cnt != 8'hFF)
              short_cnt <= short_cnt + 8'd1;
          end
        end

        S_DELAY: begin
          if (count == 32'd0) begin
            state_q  <= S_ECHO;
            count    <= width - 32'd1;
            echo_cnt <= echo_cnt + 16'd1;
          end else begin
            count <= count - 32'd1;
          end
        end

        S_ECHO: begin
          if (count == 32'd0) begin
            state_q <= S_HOLD;
            count   <= THOLD_C - 32'd1;
          end else begin
            count <= count - 32'd1;
          end
        end

        S_HOLD: begin
          // Trig still high here leaves trig_q high, so IDLE waits for a fresh rise
          if (count == 32'd0) begin
            state_q <= S_IDLE;
          end else begin
            count <= count - 32'd1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          count   <= 32'd0;
        end
      endcase
    end
  end

  // Outputs decode straight from the state register so Echo drops with Reset
  assign Echo  = (state_q == S_ECHO);
  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Bench for the ultrasonic echo responder with reduced timing constants.
// A monitor measures every Echo pulse and compares it to the queue of
// expected widths pushed when each qualifying Trig pulse is driven.
module tb_ultrasonic_echo_responder;
  import ultrasonic_pkg::*;

  localparam int unsigned P_MIN_TRIG = 5;
  localparam int unsigned P_TDELAY   = 10;
  localparam int unsigned P_MAX_ECHO = 1000;
  localparam int unsigned P_THOLD    = 20;

  logic        Clock;
  logic        Reset;
  logic        Trig;
  logic [31:0] dist_cfg;
  logic        no_target;
  logic        Echo;
  logic        busy;
  logic [2:0]  state;
  logic [7:0]  short_cnt;
  logic [15:0] echo_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned sb[$];
  int exp_echo = 0;

  int  run = 0;
  bit  in_pulse = 0;

  ultrasonic_echo_responder #(
    .MIN_TRIG (P_MIN_TRIG),
    .TDELAY   (P_TDELAY),
    .MAX_ECHO (P_MAX_ECHO),
    .THOLD    (P_THOLD)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Trig      (Trig),
    .dist_cfg  (dist_cfg),
    .no_target (no_target),
    .Echo      (Echo),
    .busy      (busy),
    .state     (state),
    .short_cnt (short_cnt),
    .echo_cnt  (echo_cnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Echo pulse monitor; a reset discards any partially observed pulse
  always @(negedge Clock) begin
    if (Reset) begin
      in_pulse = 0;
      run      = 0;
    end else if (Echo) begin
      run++;
      in_pulse = 1;
    end else if (in_pulse) begin
      in_pulse = 0;
      if (sb.size() == 0)
        check("echo_unexpected", 32'(run), 32'd0);
      else
        check("echo_width", 32'(run), sb.pop_front());
      run = 0;
    end
  end

  task automatic trig_pulse(input int n);
    @(negedge Clock);
    Trig = 1'b1;
    repeat (n) @(negedge Clock);
    Trig = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge Clock);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cfg_tab [3] = '{32'd50, 32'd5000, 32'd0};
    logic        nt_tab  [3] = '{1'b1, 1'b0, 1'b0};
    int unsigned w_tab   [3] = '{1000, 1000, 1};
    int n;

    Reset = 1'b1; Trig = 1'b0; dist_cfg = 32'd100; no_target = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_echo",  32'(Echo), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_short", 32'(short_cnt), 32'd0);
    check("rst_ecnt",  32'(echo_cnt), 32'd0);
    #1 Reset = 1'b0;
    repeat (3) @(negedge Clock);

    // 1: basic echo, fixed latency and holdoff
    dist_cfg = 32'd100;
    trig_pulse(8);
    sb.push_back(100); exp_echo++;
    repeat (12) @(negedge Clock);
    check("lat_before_rise", 32'(Echo), 32'd0);
    @(negedge Clock);
    check("lat_rise", 32'(Echo), 32'd1);
    n = 0;
    while (Echo && n < 200) begin @(negedge Clock); n++; end
    check("echo_fall_seen", 32'(Echo), 32'd0);
    repeat (19) @(negedge Clock);
    check("hold_busy", 32'(busy), 32'd1);
    @(negedge Clock);
    check("hold_release", 32'(busy), 32'd0);
    check("t1_ecnt", 32'(echo_cnt), 32'(exp_echo));

    // 2: short triggers, including one below the boundary, and saturation
    trig_pulse(3);
    repeat (4) @(negedge Clock);
    check("short_state", 32'(state), 32'(S_IDLE));
    check("short_cnt1", 32'(short_cnt), 32'd1);
    trig_pulse(4);
    repeat (4) @(negedge Clock);
    check("short_cnt_min_minus1", 32'(short_cnt), 32'd2);
    for (int i = 0; i < 298; i++) begin
      trig_pulse(3);
      repeat (4) @(negedge Clock);
    end
    check("short_sat", 32'(short_cnt), 32'd255);
    check("t2_ecnt", 32'(echo_cnt), 32'(exp_echo));

    // 3: width clamps, with trigger width exactly at the minimum
    for (int i = 0; i < 3; i++) begin
      dist_cfg  = cfg_tab[i];
      no_target = nt_tab[i];
      trig_pulse(5);
      sb.push_back(w_tab[i]); exp_echo++;
      wait_state(3'(S_IDLE), 2000, "t3_idle");
    end
    no_target = 1'b0;
    check("t3_ecnt", 32'(echo_cnt), 32'(exp_echo));

    // 4: triggers during ECHO and HOLD, and Trig held across HOLD exit
    dist_cfg = 32'd30;
    trig_pulse(5);
    sb.push_back(30); exp_echo++;
    wait_state(3'(S_ECHO), 50, "t4_echo");
    trig_pulse(5);
    wait_state(3'(S_HOLD), 100, "t4_hold");
    trig_pulse(3);
    @(negedge Clock);
    Trig = 1'b1;
    wait_state(3'(S_IDLE), 40, "t4_idle");
    repeat (10) @(negedge Clock);
    check("held_no_rearm", 32'(state), 32'(S_IDLE));
    Trig = 1'b0;
    repeat (4) @(negedge Clock);
    check("held_no_echo", 32'(echo_cnt), 32'(exp_echo));
    trig_pulse(5);
    sb.push_back(30); exp_echo++;
    wait_state(3'(S_IDLE), 200, "t4_idle2");
    check("t4_ecnt", 32'(echo_cnt), 32'(exp_echo));

    // 5: reset in the middle of an echo
    dist_cfg = 32'd100;
    trig_pulse(6);
    sb.push_back(100); exp_echo++;
    wait_state(3'(S_ECHO), 50, "t5_echo");
    repeat (40) @(negedge Clock);
    @(posedge Clock);
    #2 Reset = 1'b1;
    sb.delete();
    exp_echo = 0;
    #1;
    check("rst_mid_echo", 32'(Echo), 32'd0);
    check("rst_mid_state", 32'(state), 32'(S_IDLE));
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_short", 32'(short_cnt), 32'd0);
    check("rst_mid_ecnt", 32'(echo_cnt), 32'd0);
    @(negedge Clock);
    #1 Reset = 1'b0;
    repeat (2) @(negedge Clock);
    trig_pulse(6);
    sb.push_back(100); exp_echo++;
    wait_state(3'(S_IDLE), 300, "t5_idle");
    check("t5_ecnt", 32'(echo_cnt), 32'(exp_echo));

    // 6: config change during DELAY only affects the next pulse
    dist_cfg = 32'd100;
    trig_pulse(6);
    sb.push_back(100); exp_echo++;
    wait_state(3'(S_DELAY), 20, "t6_delay");
    dist_cfg = 32'd7;
    wait_state(3'(S_IDLE), 300, "t6_idle");
    trig_pulse(6);
    sb.push_back(7); exp_echo++;
    wait_state(3'(S_IDLE), 200, "t6_idle2");
    check("t6_ecnt", 32'(echo_cnt), 32'(exp_echo));

    repeat (3) @(negedge Clock);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
